mem_stage_lsu: RTL and testbench

//  Parametrised load/store unit for the pipeline MEM stage. Replaces the fixed 32-bit

---
 rtl/mem_stage_lsu.sv | 146 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: holds one request on a handshaked memory port, aligns store lanes,
// extracts and extends load data. Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_in,
   input  logic                is_load,
   input  logic                is_store,
   input  logic [2:0]          funct3,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   store_data,
   output logic                stall_out,
   output logic                valid_out,
   output logic [DATA_W-1:0]   load_value,
   output logic                misalign_o,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_byte_enable,
   output logic                mem_read,
   output logic                mem_write,
   input  logic                mem_resp,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [1:0]          dbg_state
);
   localparam int LANES = DATA_W / 8;
   localparam int OFF_W = $clog2(LANES);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

   state_t              r_state;
   logic                r_valid_out;
   logic                r_misalign;
   logic [DATA_W-1:0]   r_load_value;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [LANES-1:0]    r_be;
   logic                r_read;
   logic                r_write;
   logic [2:0]          r_funct3;
   logic [OFF_W-1:0]    r_off_al;

   logic [OFF_W-1:0]    w_off;
   logic [OFF_W-1:0]    w_low_mask;
   logic [OFF_W-1:0]    w_off_al;
   logic [LANES-1:0]    w_be;
   logic [DATA_W-1:0]   w_wdata;
   logic                w_legal;
   logic                w_memop;
   logic                w_mis;
   logic                w_go;
   logic [DATA_W-1:0]   w_rsh;
   logic [7:0]          w_k;
   logic [DATA_W-1:0]   w_tmp;
   logic [DATA_W-1:0]   w_zext;
   logic signed [DATA_W-1:0] w_sext;
   logic [DATA_W-1:0]   w_ext;

   // Request decode: access size from funct3[1:0], lane offset aligned down to the size.
   assign w_off      = addr[OFF_W-1:0];
   assign w_low_mask = OFF_W'((4'd1 << funct3[1:0]) - 4'd1);
   assign w_off_al   = w_off & ~w_low_mask;
   assign w_be       = LANES'(((16'd1 << (5'd1 << funct3[1:0])) - 16'd1) << w_off_al);
   assign w_wdata    = store_data << {w_off_al, 3'b000};
   assign w_legal    = (funct3 != 3'b111) &&
                       ((DATA_W == 64) || ((funct3[1:0] != 2'b11) && (funct3 != 3'b110)));
   assign w_memop    = (is_load | is_store) & w_legal;
`ifdef MEM_MISALIGN_TRAP_EN
   assign w_mis      = w_memop & (w_off != w_off_al);
`else
   assign w_mis      = 1'b0;
`endif
   assign w_go       = w_memop & ~w_mis;

   // Load path: bring the addressed bytes to bit 0, then extend by shifting up and back down.
   assign w_rsh  = mem_rdata >> {r_off_al, 3'b000};
   assign w_k    = 8'(DATA_W) - {1'b0, (4'd1 << r_funct3[1:0]), 3'b000};
   assign w_tmp  = w_rsh << w_k;
   assign w_zext = w_tmp >> w_k;
   assign w_sext = $signed(w_tmp) >>> w_k;
   assign w_ext  = r_funct3[2] ? w_zext : w_sext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_valid_out  <= 1'b0;
         r_misalign   <= 1'b0;
         r_load_value <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_be         <= '0;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_funct3     <= '0;
         r_off_al     <= '0;
      end else begin
         r_valid_out  <= 1'b0;
         r_misalign   <= 1'b0;
         r_load_value <= '0;
         case (r_state)
            S_IDLE: begin
               if (valid_in && w_go) begin
                  r_addr   <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  r_wdata  <= w_wdata;
                  r_be     <= w_be;
                  r_read   <= is_load;
                  r_write  <= is_store;
                  r_funct3 <= funct3;
                  r_off_al <= w_off_al;
                  r_state  <= S_BUSY;
               end else if (valid_in) begin
                  r_valid_out <= 1'b1;
                  r_misalign  <= w_mis;
               end
            end
            S_BUSY: begin
               if (mem_resp) begin
                  r_load_value <= r_read ? w_ext : '0;
                  r_valid_out  <= 1'b1;
                  r_read       <= 1'b0;
                  r_write      <= 1'b0;
                  r_be         <= '0;
                  r_wdata      <= '0;
                  r_state      <= S_DONE;
               end
            end
            // The slot upstream still holds the completed op here; it advances as stall drops.
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall_out       = ((r_state == S_IDLE) & valid_in & w_go) | (r_state == S_BUSY);
   assign valid_out       = r_valid_out;
   assign load_value      = r_load_value;
   assign misalign_o      = r_misalign;
   assign mem_address     = r_addr;
   assign mem_wdata       = r_wdata;
   assign mem_byte_enable = r_be;
   assign mem_read        = r_read;
   assign mem_write       = r_write;
   assign dbg_state       = r_state;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: a 32-bit and a 64-bit instance share stimulus, one selected per op;
// expected load results are queued at issue and compared when valid_out fires.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel64 = 1'b0;
  logic        valid_in = 1'b0, is_load = 1'b0, is_store = 1'b0, mem_resp = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [63:0] store_data = '0, mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  logic        stall_a, valid_a, mis_a, rd_a, wr_a;
  logic [31:0] load_a, maddr_a, wdata_a;
  logic [3:0]  be_a;
  logic [1:0]  dbg_a;
  logic        stall_b, valid_b, mis_b, rd_b, wr_b;
  logic [63:0] load_b, wdata_b;
  logic [31:0] maddr_b;
  logic [7:0]  be_b;
  logic [1:0]  dbg_b;

  logic        vin_a, vin_b, resp_a, resp_b;
  logic        m_stall, m_valid, m_mis, m_rd, m_wr;
  logic [63:0] m_load, m_wdata;
  logic [31:0] m_addr;
  logic [7:0]  m_be;

  assign vin_a   = valid_in & ~sel64;
  assign vin_b   = valid_in & sel64;
  assign resp_a  = mem_resp & ~sel64;
  assign resp_b  = mem_resp & sel64;
  assign m_stall = sel64 ? stall_b : stall_a;
  assign m_valid = sel64 ? valid_b : valid_a;
  assign m_mis   = sel64 ? mis_b : mis_a;
  assign m_rd    = sel64 ? rd_b : rd_a;
  assign m_wr    = sel64 ? wr_b : wr_a;
  assign m_load  = sel64 ? load_b : {32'b0, load_a};
  assign m_wdata = sel64 ? wdata_b : {32'b0, wdata_a};
  assign m_addr  = sel64 ? maddr_b : maddr_a;
  assign m_be    = sel64 ? be_b : {4'b0, be_a};

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .valid_in(vin_a), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data[31:0]),
    .stall_out(stall_a), .valid_out(valid_a), .load_value(load_a), .misalign_o(mis_a),
    .mem_address(maddr_a), .mem_wdata(wdata_a), .mem_byte_enable(be_a),
    .mem_read(rd_a), .mem_write(wr_a), .mem_resp(resp_a), .mem_rdata(mem_rdata[31:0]),
    .dbg_state(dbg_a)
  );

  mem_stage_lsu #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .valid_in(vin_b), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .stall_out(stall_b), .valid_out(valid_b), .load_value(load_b), .misalign_o(mis_b),
    .mem_address(maddr_b), .mem_wdata(wdata_b), .mem_byte_enable(be_b),
    .mem_read(rd_b), .mem_write(wr_b), .mem_resp(resp_b), .mem_rdata(mem_rdata),
    .dbg_state(dbg_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-by-byte reference for lane selection, store placement and load extension.
  task automatic model(input bit w64, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] sd, input logic [63:0] rd,
                       output logic [7:0] be, output logic [63:0] wd, output logic [63:0] ld,
                       output logic [31:0] ma, output bit mis);
    int lanes, off, sz, offal;
    lanes = w64 ? 8 : 4;
    off   = int'(a % lanes);
    sz    = 1 << f3[1:0];
    offal = off - (off % sz);
    be = '0; wd = '0; ld = '0;
    ma  = a - off;
    mis = (off != offal);
    for (int i = 0; i < sz; i++) begin
      be[offal+i]          = 1'b1;
      wd[8*(offal+i) +: 8] = sd[8*i +: 8];
      ld[8*i +: 8]         = rd[8*(offal+i) +: 8];
    end
    if (!f3[2] && ld[8*sz-1])
      for (int i = sz; i < lanes; i++) ld[8*i +: 8] = 8'hFF;
  endtask

  // driver: one op from IDLE, memory answers after 'waits' busy cycles
  task automatic do_op(input bit w64, input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [63:0] sd, input logic [63:0] rd,
                       input int waits);
    logic [7:0]  ebe;
    logic [63:0] ewd, eld, mask;
    logic [31:0] ema;
    bit mis, legal, memop, emis, go;
    int n;
    model(w64, f3, a, sd, rd, ebe, ewd, eld, ema, mis);
    legal = (f3 != 3'b111) && (w64 || (f3 != 3'b011 && f3 != 3'b110));
    memop = (ld || st) && legal;
    emis  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    emis  = memop && mis;
`endif
    go = memop && !emis;
    mask = '0;
    for (int i = 0; i < 8; i++) if (ebe[i]) mask[8*i +: 8] = 8'hFF;
    exp_q.push_back((go && ld) ? eld : 64'h0);

    sel64 = w64; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    valid_in = 1'b1;
    #1;
    check("stall_issue", m_stall, go);
    @(negedge clk);
    if (go) begin
      check("req_read", m_rd, ld);
      check("req_write", m_wr, st);
      check("mem_addr", m_addr, ema);
      check("byte_en", m_be, ebe);
      if (st) check("wdata", m_wdata & mask, ewd);
      n = 1;
      for (int w = 0; w < waits; w++) begin
        n += m_stall;
        @(negedge clk);
      end
      mem_resp = 1'b1; mem_rdata = rd;
      n += m_stall;
      @(negedge clk);
      mem_resp = 1'b0;
      check("stall_cycles", n, waits + 2);
    end
    valid_in = 1'b0;
    #1;
    for (int k = 0; k < 8 && !m_valid; k++) @(negedge clk);
    check("valid_out", m_valid, 1'b1);
    check("stall_done", m_stall, 1'b0);
    check("req_clear", m_rd | m_wr, 1'b0);
    check("misalign", m_mis, emis);
    if (m_valid && exp_q.size() > 0) check("load_value", m_load, exp_q.pop_front());
    @(negedge clk);
    check("valid_pulse", m_valid, 1'b0);
  endtask

  initial begin
    bit w64, ld, u;
    int sz;
    repeat (2) @(negedge clk);
    check("rst_stall32", stall_a, 1'b0);
    check("rst_valid32", valid_a, 1'b0);
    check("rst_req32", rd_a | wr_a, 1'b0);
    check("rst_valid64", valid_b, 1'b0);
    check("rst_load64", load_b, 64'h0);
    check("rst_be64", be_b, 8'h0);
    rst = 1'b0;
    @(negedge clk);

    do_op(1'b0, 1'b0, 1'b1, 3'b010, 32'h104, 64'hDEADBEEF, 64'h0, 2);       // sw
    do_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h203, 64'hA5, 64'h0, 0);             // sb
    do_op(1'b0, 1'b1, 1'b0, 3'b000, 32'h102, 64'h0, 64'h0080_0000, 1);      // lb
    do_op(1'b0, 1'b1, 1'b0, 3'b100, 32'h102, 64'h0, 64'h0080_0000, 0);      // lbu
    do_op(1'b0, 1'b1, 1'b0, 3'b001, 32'h106, 64'h0, 64'h8001_0000, 0);      // lh
    do_op(1'b1, 1'b1, 1'b0, 3'b011, 32'h8, 64'h0, 64'h0123456789ABCDEF, 1); // ld
    do_op(1'b1, 1'b1, 1'b0, 3'b110, 32'hC, 64'h0, 64'h0123456789ABCDEF, 0); // lwu
    do_op(1'b1, 1'b0, 1'b1, 3'b011, 32'h10, 64'h1122334455667788, 64'h0, 3);// sd
    do_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h101, 64'h0, 64'hCAFEF00D, 0);       // misaligned lw
    do_op(1'b0, 1'b0, 1'b0, 3'b010, 32'h40, 64'h0, 64'h0, 0);               // non-mem op
    do_op(1'b0, 1'b1, 1'b0, 3'b111, 32'h40, 64'h0, 64'h0, 0);               // illegal funct3
    do_op(1'b0, 1'b1, 1'b0, 3'b011, 32'h40, 64'h0, 64'h0, 0);               // ld on 32-bit

    // reset while BUSY: request and stall drop at once, no completion follows
    sel64 = 1'b0; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h80;
    valid_in = 1'b1;
    @(negedge clk);
    check("busy_read", rd_a, 1'b1);
    valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_busy_read", rd_a, 1'b0);
    check("rst_busy_stall", stall_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_valid", valid_a, 1'b0);
    end
    do_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h84, 64'h0, 64'h89ABCDEF, 1);

    for (int r = 0; r < 16; r++) begin
      w64 = 1'($urandom_range(0, 1));
      ld  = 1'($urandom_range(0, 1));
      sz  = $urandom_range(0, w64 ? 3 : 2);
      u   = (ld && sz < (w64 ? 3 : 2)) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_op(w64, ld, !ld, {u, 2'(sz)}, 32'($urandom_range(0, 4095)),
            {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
